ysyx_24100005_mem_arbiter: RTL
==============================

Name: ysyx_24100005_mem_arbiter

Overview:
- Two-master, one-slave arbiter for the NPC's single memory port.
- Masters: instruction fetch (IFU, read-only) and load/store unit (LSU, read/write).
- It accepts one request at a time, forwards it to the memory-side port, and routes the response back to the owner.
- It sits between IFU/LSU and the DPI-backed memory wrapper (npcmem_read/npcmem_write), replacing direct combinational memory calls from the top level.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MASK_W, 8, write byte-mask width (matches the npcmem_write wmask byte).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  IFU read address
- ifu_rsp_valid  out  1  IFU read data valid
- ifu_rsp_ready  in  1  IFU can take response
- ifu_rdata  out  DATA_W  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_W  LSU address
- lsu_wen  in  1  1 = write, 0 = read
- lsu_wdata  in  DATA_W  LSU write data
- lsu_wmask  in  MASK_W  LSU byte mask
- lsu_rsp_valid  out  1  LSU response valid (read data or write ack)
- lsu_rsp_ready  in  1  LSU can take response
- lsu_rdata  out  DATA_W  LSU read data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_W  latched address
- mem_wen  out  1  latched write enable
- mem_wdata  out  DATA_W  latched write data
- mem_wmask  out  MASK_W  latched mask (0 for IFU)
- mem_rsp_valid  in  1  memory response valid
- mem_rsp_ready  out  1  arbiter accepts response
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Handshake rule: a transfer occurs on a rising clk edge where valid && ready. Masters hold request fields stable while valid is high and not yet accepted.
- FSM states and transitions:
  - IDLE -> REQ on grant.
  - REQ -> RSP on mem_req_valid && mem_req_ready.
  - RSP -> IDLE on mem_rsp_valid && mem_rsp_ready.
- IDLE behaviour:
  - Arbitrate combinationally.
  - Assert exactly one of ifu_req_ready/lsu_req_ready, to the granted master only, for one cycle.
  - On the accept edge, latch addr/wen/wdata/wmask and owner, and go to REQ.
  - IFU grant latches wen=0, wmask=0, wdata=0.
- Arbitration is round-robin:
  - If only one master is valid, it wins.
  - If both are valid, the master not granted last wins.
  - last_grant resets to LSU, so IFU wins the first conflict.
- REQ: mem_req_valid=1 with the latched fields, held until mem_req_ready. Both req_ready outputs are 0.
- RSP:
  - mem_rsp_ready = owner's rsp_ready.
  - owner's rsp_valid = mem_rsp_valid.
  - owner's rdata = mem_rdata.
  - The non-owner's rsp_valid=0 and rdata=0.
  - Stall indefinitely while the owner's rsp_ready is low.
- Latency:
  - Request accepted at edge N.
  - mem_req_valid is high from cycle N+1.
  - With mem_req_ready and mem_rsp_valid tied high and the owner's rsp_ready high: response at cycle N+2, next accept possible at edge N+3.
- Outputs are registered from state/latches, except rsp routing and req_ready, which are combinational from state.
- Only one outstanding transaction. New requests are ignored (ready=0) outside IDLE.
- Reset (rst=0, any time, including mid-transaction):
  - State goes immediately to IDLE and latches clear to 0.
  - last_grant resets to LSU.
  - All valid/ready outputs are 0, except mem_rsp_ready=0.
  - An in-flight response is dropped, and masters re-issue after reset.
- Writes: the LSU receives lsu_rsp_valid on write completion; lsu_rdata then carries mem_rdata, which is don't-care for writes.
- mem_req_ready or mem_rsp_valid arriving in the wrong state is ignored.

Test Plan:
- Reset then single IFU read:
  - Stimulus: rst low 3 cycles, release; ifu_req_valid=1, ifu_addr=0x8000_0000; mem returns 0x0000_0413.
  - Required: ifu_req_ready pulse at edge N, mem_addr=0x8000_0000, mem_wen=0, mem_wmask=0x00, ifu_rdata=0x0000_0413 at N+2, lsu_rsp_valid=0 throughout.
- Simultaneous requests:
  - Stimulus: both valid after reset.
  - Required: IFU granted first; LSU granted on the next IDLE; then with both still valid, IFU again (alternation IFU, LSU, IFU).
- LSU write:
  - Stimulus: lsu_wen=1, addr=0x8000_0100, wdata=0xDEAD_BEEF, wmask=0x0F.
  - Required: mem sees exactly those fields with mem_wen=1; lsu_rsp_valid pulses once.
- Backpressure:
  - Stimulus: mem_req_ready low 4 cycles, then lsu_rsp_ready low 3 cycles.
  - Required: mem request fields stable while stalled; mem_rsp_ready=0 until lsu_rsp_ready=1; no new grants meanwhile.
- Reset mid-transaction:
  - Stimulus: assert rst in RSP.
  - Required: mem_req_valid, both rsp_valid, and both req_ready go to 0 asynchronously, before the next clk edge; after release, first conflict goes to IFU.

Source files
------------

// File: rtl/ysyx_24100005_mem_arbiter_if.sv
// Bundles the IFU and LSU request/response ports and the single memory-side port of the NPC memory arbiter.
interface ysyx_24100005_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MASK_W = 8
);
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_rsp_valid;
  logic              ifu_rsp_ready;
  logic [DATA_W-1:0] ifu_rdata;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_wen;
  logic [DATA_W-1:0] lsu_wdata;
  logic [MASK_W-1:0] lsu_wmask;
  logic              lsu_rsp_valid;
  logic              lsu_rsp_ready;
  logic [DATA_W-1:0] lsu_rdata;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_rsp_valid;
  logic              mem_rsp_ready;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view: serves the two masters, drives the memory port.
  modport slave (
    input  ifu_req_valid, ifu_addr, ifu_rsp_ready,
    output ifu_req_ready, ifu_rsp_valid, ifu_rdata,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_rsp_ready,
    output lsu_req_ready, lsu_rsp_valid, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_rsp_ready,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  // Environment view: IFU, LSU and the memory wrapper.
  modport master (
    output ifu_req_valid, ifu_addr, ifu_rsp_ready,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rdata,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_rsp_ready,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_rsp_ready,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/ysyx_24100005_mem_arbiter.sv
// Round-robin arbiter letting IFU and LSU share the single memory port, one outstanding transaction at a time.
module ysyx_24100005_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MASK_W = 8
) (
  input logic                          clk,
  input logic                          rst,
  ysyx_24100005_mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  state_t state;
  owner_t owner;
  owner_t last_grant;

  logic grant_ifu;
  logic grant_lsu;
  logic owner_rsp_ready;
  logic rsp_fire;
  logic in_rsp;

  // Round-robin pick: a lone requester wins, on conflict the one not served last wins.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state == IDLE) begin
      grant_ifu = bus.ifu_req_valid && (!bus.lsu_req_valid || (last_grant == OWN_LSU));
      grant_lsu = bus.lsu_req_valid && !grant_ifu;
    end
  end

  // Request acceptance and response routing, all decoded from the current state.
  always_comb begin
    in_rsp          = (state == RSP);
    owner_rsp_ready = (owner == OWN_LSU) ? bus.lsu_rsp_ready : bus.ifu_rsp_ready;
    rsp_fire        = in_rsp && bus.mem_rsp_valid && owner_rsp_ready;

    // Gated by rst so the masters never see an accept while reset is held.
    bus.ifu_req_ready = rst && grant_ifu;
    bus.lsu_req_ready = rst && grant_lsu;

    bus.mem_rsp_ready = in_rsp && owner_rsp_ready;
    bus.ifu_rsp_valid = in_rsp && (owner == OWN_IFU) && bus.mem_rsp_valid;
    bus.lsu_rsp_valid = in_rsp && (owner == OWN_LSU) && bus.mem_rsp_valid;
    bus.ifu_rdata     = (in_rsp && (owner == OWN_IFU)) ? bus.mem_rdata : DATA_W'(0);
    bus.lsu_rdata     = (in_rsp && (owner == OWN_LSU)) ? bus.mem_rdata : DATA_W'(0);
  end

  // Transaction FSM with the latched memory request fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      owner             <= OWN_IFU;
      last_grant        <= OWN_LSU;
      bus.mem_req_valid <= 1'b0;
      bus.mem_addr      <= ADDR_W'(0);
      bus.mem_wen       <= 1'b0;
      bus.mem_wdata     <= DATA_W'(0);
      bus.mem_wmask     <= MASK_W'(0);
    end else begin
      case (state)
        IDLE: begin
          if (grant_ifu) begin
            state             <= REQ;
            owner             <= OWN_IFU;
            last_grant        <= OWN_IFU;
            bus.mem_req_valid <= 1'b1;
            bus.mem_addr      <= bus.ifu_addr;
            bus.mem_wen       <= 1'b0;
            bus.mem_wdata     <= DATA_W'(0);
            bus.mem_wmask     <= MASK_W'(0);
          end else if (grant_lsu) begin
            state             <= REQ;
            owner             <= OWN_LSU;
            last_grant        <= OWN_LSU;
            bus.mem_req_valid <= 1'b1;
            bus.mem_addr      <= bus.lsu_addr;
            bus.mem_wen       <= bus.lsu_wen;
            bus.mem_wdata     <= bus.lsu_wdata;
            bus.mem_wmask     <= bus.lsu_wmask;
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            state             <= RSP;
            bus.mem_req_valid <= 1'b0;
          end
        end
        RSP: begin
          if (rsp_fire) begin
            state <= IDLE;
          end
        end
        default: begin
          state             <= IDLE;
          bus.mem_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
